// File: rtl/spike_encoder_mc.sv
// Multi-channel spike encoder on the TinyQV register bus.
// Each channel fires either on a level threshold or as a leaky integrate-and-fire neuron.
module spike_encoder_mc #(
  parameter int NCH   = 4,
  parameter int ACC_W = 12,
  parameter int REF_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam logic [ACC_W:0] SAT = {1'b0, {ACC_W{1'b1}}};

  logic [7:0]       in_reg [NCH];
  logic [7:0]       thresh;
  logic [5:0]       ctrl;
  logic [REF_W-1:0] refract;
  logic [NCH-1:0]   status;
  logic [7:0]       count;
  logic [NCH-1:0]   spike;
  logic [NCH-1:0]   spike_next;
  logic [NCH-1:0]   clr;
  logic [7:0]       pc;
  logic             en;
  logic             mode;
  logic [2:0]       leak_sh;
  logic             src;
  logic [ACC_W:0]   thr;

  assign en      = ctrl[0];
  assign mode    = ctrl[1];
  assign leak_sh = ctrl[4:2];
  assign src     = ctrl[5];
  assign thr     = {1'b0, thresh, {(ACC_W-8){1'b0}}};
  assign clr     = (data_write && address == 4'h7) ? data_in[NCH-1:0] : '0;
  assign uo_out  = {{(8-NCH){1'b0}}, spike};

  // Per-channel datapath; all decisions use register values from before the current edge
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [7:0]       x;
    logic [ACC_W-1:0] leak;
    logic [ACC_W:0]   sum_raw;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_n;
    logic [REF_W-1:0] ref_cnt;
    logic [REF_W-1:0] ref_n;
    logic             spike_q;
    logic             spike_n;

    if (g == 0) begin : g_src
      assign x = src ? ui_in : in_reg[0];
    end else begin : g_reg
      assign x = in_reg[g];
    end

    // acc - leak never underflows, so one extra bit is enough to catch overflow
    assign leak    = (leak_sh == 3'd0) ? '0 : (acc >> leak_sh);
    assign sum_raw = {1'b0, acc} - {1'b0, leak} + {{(ACC_W-7){1'b0}}, x};
    assign sum     = (sum_raw > SAT) ? SAT : sum_raw;

    always_comb begin
      acc_n   = acc;
      ref_n   = ref_cnt;
      spike_n = 1'b0;
      if (en) begin
        if (!mode) begin
          acc_n   = '0;
          ref_n   = '0;
          spike_n = (x > thresh);
        end else if (ref_cnt != '0) begin
          ref_n = ref_cnt - REF_W'(1);
          acc_n = '0;
        end else if (sum >= thr) begin
          spike_n = 1'b1;
          acc_n   = '0;
          ref_n   = refract;
        end else begin
          acc_n = sum[ACC_W-1:0];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc     <= '0;
        ref_cnt <= '0;
        spike_q <= 1'b0;
      end else begin
        acc     <= acc_n;
        ref_cnt <= ref_n;
        spike_q <= spike_n;
      end
    end

    assign spike_next[g] = spike_n;
    assign spike[g]      = spike_q;
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < NCH; i++) begin
      pc = pc + 8'(spike_next[i]);
    end
  end

  // A spike on the same edge as a STATUS clear or COUNT write takes precedence
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        in_reg[i] <= '0;
      end
      thresh  <= '0;
      ctrl    <= '0;
      refract <= '0;
      status  <= '0;
      count   <= '0;
    end else begin
      if (data_write) begin
        case (address)
          4'h4:    thresh  <= data_in;
          4'h5:    ctrl    <= data_in[5:0];
          4'h6:    refract <= data_in[REF_W-1:0];
          default: ;
        endcase
      end
      for (int i = 0; i < NCH; i++) begin
        if (data_write && address == 4'(i)) begin
          in_reg[i] <= data_in;
        end
      end
      status <= (status & ~clr) | spike_next;
      count  <= (data_write && address == 4'h8) ? pc : count + pc;
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      4'h4: data_out = thresh;
      4'h5: data_out = {2'b00, ctrl};
      4'h6: data_out = 8'(refract);
      4'h7: data_out = 8'(status);
      4'h8: data_out = count;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (address == 4'(i)) begin
            data_out = in_reg[i];
          end
        end
      end
    endcase
  end

endmodule
